// File: rtl/vs_sci_pkg.sv
// Shared VS1003 SCI definitions: opcodes, register addresses, writer FSM states.
// Also provides the helper that assembles a 32-bit SCI write frame.
package vs_sci_pkg;

  localparam logic [7:0] SCI_OP_WRITE = 8'h02;
  localparam logic [7:0] SCI_OP_READ  = 8'h03;

  localparam logic [7:0] SCI_MODE = 8'h00;
  localparam logic [7:0] SCI_VOL  = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DREQ = 3'd2,
    ST_SETUP     = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_HOLD      = 3'd5,
    ST_RELEASE   = 3'd6
  } vs_state_e;

  function automatic logic [31:0] sci_write_word(input logic [7:0] addr,
                                                 input logic [15:0] data);
    return {SCI_OP_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/sci_shift_tx.sv
// Generic 32-bit MSB-first serial transmitter: each bit is SCLK low for CLK_DIV
// cycles then high for CLK_DIV cycles; SI only moves when SCLK falls.
module sci_shift_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data,
  output logic        o_sclk,
  output logic        o_si,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic        r_active;
  logic        r_high;
  logic [7:0]  r_cnt;
  logic [4:0]  r_bit;
  logic [31:0] r_shreg;

  logic w_phase_end;

  assign w_phase_end = r_active && (r_cnt == DIV_M1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_high   <= 1'b0;
      r_cnt    <= 8'd0;
      r_bit    <= 5'd0;
      r_shreg  <= 32'd0;
    end else if (i_start && !r_active) begin
      r_active <= 1'b1;
      r_high   <= 1'b0;
      r_cnt    <= 8'd0;
      r_bit    <= 5'd31;
      r_shreg  <= i_data;
    end else if (r_active) begin
      if (w_phase_end) begin
        r_cnt <= 8'd0;
        if (!r_high) begin
          r_high <= 1'b1;
        end else begin
          r_high <= 1'b0;
          // The last bit stays on SI after the frame so the line is quiet during hold.
          if (r_bit == 5'd0) begin
            r_active <= 1'b0;
          end else begin
            r_bit   <= r_bit - 5'd1;
            r_shreg <= {r_shreg[30:0], 1'b0};
          end
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_sclk = r_active & r_high;
  assign o_si   = r_shreg[31];
  assign o_busy = r_active;
  assign o_done = w_phase_end && r_high && (r_bit == 5'd0);

endmodule

// File: rtl/vol_sci_writer.sv
// Writes VOL to the VS1003 SCI_VOL register whenever it differs from the value
// last written, arbitrating for the shared SCI bus and waiting on DREQ.
module vol_sci_writer
  import vs_sci_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter logic [7:0] VOL_ADDR = SCI_VOL
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] VOL,
  input  logic        DREQ,
  input  logic        BUS_GNT,
  output logic        BUS_REQ,
  output logic        XCS,
  output logic        SCLK,
  output logic        SI,
  output logic        BUSY,
  output logic        DONE,
  output vs_state_e   DBG_STATE
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  vs_state_e   r_state;
  vs_state_e   w_next;
  logic [15:0] r_sent_vol;
  logic        r_pending;
  logic [31:0] r_word;
  logic [7:0]  r_cnt;

  logic w_cnt_end;
  logic w_start;
  logic w_tx_sclk;
  logic w_tx_si;
  logic w_tx_busy;
  logic w_tx_done;

  assign w_cnt_end = (r_cnt == DIV_M1);

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sent_vol <= 16'h0000;
      r_pending  <= 1'b1;
      r_word     <= 32'd0;
      r_cnt      <= 8'd0;
    end else begin
      // On completion, pending survives only if VOL moved on during the frame.
      if (r_state == ST_RELEASE) begin
        r_sent_vol <= r_word[15:0];
        r_pending  <= (r_word[15:0] != VOL);
      end else if (VOL != r_sent_vol) begin
        r_pending <= 1'b1;
      end
      if (r_state == ST_WAIT_DREQ && DREQ) r_word <= sci_write_word(VOL_ADDR, VOL);
      if ((r_state == ST_SETUP || r_state == ST_HOLD) && !w_cnt_end) r_cnt <= r_cnt + 8'd1;
      else                                                          r_cnt <= 8'd0;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      ST_IDLE:      if (r_pending) w_next = ST_REQ;
      ST_REQ:       if (BUS_GNT) w_next = ST_WAIT_DREQ;
      ST_WAIT_DREQ: if (DREQ) w_next = ST_SETUP;
      ST_SETUP: begin
        if (w_cnt_end && !w_tx_busy) begin
          w_next  = ST_SHIFT;
          w_start = 1'b1;
        end
      end
      ST_SHIFT:     if (w_tx_done) w_next = ST_HOLD;
      ST_HOLD:      if (w_cnt_end) w_next = ST_RELEASE;
      ST_RELEASE:   w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  sci_shift_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_start (w_start),
    .i_data  (r_word),
    .o_sclk  (w_tx_sclk),
    .o_si    (w_tx_si),
    .o_busy  (w_tx_busy),
    .o_done  (w_tx_done)
  );

  assign BUS_REQ   = (r_state != ST_IDLE) && (r_state != ST_RELEASE);
  assign XCS       = !(r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD);
  assign SCLK      = (r_state == ST_SHIFT) && w_tx_sclk;
  assign SI        = (r_state == ST_SETUP) ? r_word[31] :
                     (r_state == ST_SHIFT || r_state == ST_HOLD) ? w_tx_si : 1'b0;
  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = (r_state == ST_RELEASE);
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_vol_sci_writer.sv
// Bench for vol_sci_writer: CLK_DIV=4 instance for the main sequences plus a
// CLK_DIV=1 instance; SI frames are reassembled and checked against a queue.
module tb_vol_sci_writer;
  import vs_sci_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, dreq, gnt;
  logic [15:0] vol;
  logic        bus_req, xcs, sclk, si, busy, done;
  vs_state_e   dbg_state;

  logic        rst1_n, dreq1, gnt1;
  logic [15:0] vol1;
  logic        bus_req1, xcs1, sclk1, si1, busy1, done1;
  vs_state_e   dbg_state1;

  vol_sci_writer #(.CLK_DIV(4), .VOL_ADDR(8'h0B)) dut (
    .CLK(clk), .RST_N(rst_n), .VOL(vol), .DREQ(dreq), .BUS_GNT(gnt),
    .BUS_REQ(bus_req), .XCS(xcs), .SCLK(sclk), .SI(si), .BUSY(busy),
    .DONE(done), .DBG_STATE(dbg_state)
  );

  vol_sci_writer #(.CLK_DIV(1), .VOL_ADDR(8'h0B)) dut1 (
    .CLK(clk), .RST_N(rst1_n), .VOL(vol1), .DREQ(dreq1), .BUS_GNT(gnt1),
    .BUS_REQ(bus_req1), .XCS(xcs1), .SCLK(sclk1), .SI(si1), .BUSY(busy1),
    .DONE(done1), .DBG_STATE(dbg_state1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_frames = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame monitor, CLK_DIV=4 instance
  logic        m_prev_sclk = 1'b0, m_prev_xcs = 1'b1, m_prev_si = 1'b0;
  int          m_bits = 0, m_low = 0, m_si_bad = 0;
  logic [31:0] m_word = 32'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_bits = 0; m_low = 0; m_word = 32'd0; m_si_bad = 0;
    end else begin
      if (!xcs) m_low++;
      if (sclk && m_prev_sclk && (si !== m_prev_si)) m_si_bad++;
      if (sclk && !m_prev_sclk && !xcs) begin
        m_word = {m_word[30:0], si};
        m_bits++;
      end
      if (xcs && !m_prev_xcs) begin
        n_frames++;
        check("frame_bits", m_bits, 32);
        check("xcs_low_len", m_low, 264);
        check("si_stable_while_sclk_high", m_si_bad, 0);
        check("done_with_xcs_rise", {31'd0, done}, 32'd1);
        if (exp_q.size() == 0) check("unexpected_frame", m_word, 32'hxxxxxxxx);
        else                   check("frame_word", m_word, exp_q.pop_front());
        m_bits = 0; m_low = 0; m_word = 32'd0; m_si_bad = 0;
      end
    end
    m_prev_sclk = sclk; m_prev_xcs = xcs; m_prev_si = si;
  end

  // Frame monitor, CLK_DIV=1 instance; also measures SCLK period
  logic        m1_prev_sclk = 1'b0, m1_prev_xcs = 1'b1;
  int          m1_bits = 0, m1_low = 0, m1_bad_period = 0, m1_last_rise = -1, cyc = 0;
  logic [31:0] m1_word = 32'd0;

  always @(negedge clk) begin
    cyc++;
    if (!rst1_n) begin
      m1_bits = 0; m1_low = 0; m1_word = 32'd0; m1_bad_period = 0; m1_last_rise = -1;
    end else begin
      if (!xcs1) m1_low++;
      if (sclk1 && !m1_prev_sclk && !xcs1) begin
        m1_word = {m1_word[30:0], si1};
        m1_bits++;
        if (m1_last_rise >= 0 && (cyc - m1_last_rise) != 2) m1_bad_period++;
        m1_last_rise = cyc;
      end
      if (xcs1 && !m1_prev_xcs) begin
        check("div1_frame_bits", m1_bits, 32);
        check("div1_xcs_low_len", m1_low, 66);
        check("div1_sclk_period", m1_bad_period, 0);
        if (exp1_q.size() == 0) check("div1_unexpected_frame", m1_word, 32'hxxxxxxxx);
        else                    check("div1_frame_word", m1_word, exp1_q.pop_front());
        m1_bits = 0; m1_low = 0; m1_word = 32'd0; m1_bad_period = 0; m1_last_rise = -1;
      end
    end
    m1_prev_sclk = sclk1; m1_prev_xcs = xcs1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit which, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((which ? done1 : done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] vol;
    int          gnt_hold;
    int          dreq_hold;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad;
    int frames0;
    bit hit;

    vecs[0] = '{16'h1010,  50,   0, 32'h020B1010};
    vecs[1] = '{16'h2020,   0, 100, 32'h020B2020};
    vecs[2] = '{16'h00FF,   0,   0, 32'h020B00FF};
    vecs[3] = '{16'hFFFF,   0,   0, 32'h020BFFFF};
    vecs[4] = '{16'h0000,   0,   0, 32'h020B0000};
    vecs[5] = '{16'hF0F0,   0,   0, 32'h020BF0F0};

    rst_n = 1'b0; vol = 16'h0000; gnt = 1'b1; dreq = 1'b1;
    rst1_n = 1'b0; vol1 = 16'hF0F0; gnt1 = 1'b1; dreq1 = 1'b1;
    repeat (3) tick();

    check("reset_outputs", {26'd0, bus_req, xcs, sclk, si, busy, done}, 32'b010000);
    check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Post-reset write of VOL=0 even though it equals the reset sent value
    exp_q.push_back(32'h020B0000);
    rst_n = 1'b1;
    tick();
    check("post_reset_bus_req", {31'd0, bus_req}, 32'd1);
    wait_done(1'b0, 1000, "post_reset_done");
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (5) tick();
    check("idle_after_first", {30'd0, busy, bus_req}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      if (vecs[k].gnt_hold > 0) gnt = 1'b0;
      if (vecs[k].dreq_hold > 0) dreq = 1'b0;
      vol = vecs[k].vol;
      exp_q.push_back(vecs[k].exp_word);
      if (vecs[k].gnt_hold > 0) begin
        bad = 0;
        for (int c = 0; c < vecs[k].gnt_hold; c++) begin
          tick();
          if (xcs !== 1'b1 || sclk !== 1'b0) bad++;
        end
        check("no_gnt_bus_idle", bad, 0);
        check("no_gnt_bus_req", {31'd0, bus_req}, 32'd1);
        gnt = 1'b1;
      end
      if (vecs[k].dreq_hold > 0) begin
        bad = 0;
        for (int c = 0; c < vecs[k].dreq_hold; c++) begin
          tick();
          if (xcs !== 1'b1 || sclk !== 1'b0) bad++;
        end
        check("no_dreq_bus_idle", bad, 0);
        check("no_dreq_state", {29'd0, dbg_state}, {29'd0, ST_WAIT_DREQ});
        dreq = 1'b1;
        tick();
        check("dreq_rise_xcs_low", {31'd0, xcs}, 32'd0);
      end
      wait_done(1'b0, 1000, "vec_done");
      repeat (4) tick();
    end

    // Coalescing: 0x2020 must never go out, only 0x3030 after the running frame
    frames0 = n_frames;
    vol = 16'h1010;
    exp_q.push_back(32'h020B1010);
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (xcs === 1'b0) begin hit = 1'b1; break; end
    end
    check("coalesce_frame_start", {31'd0, hit}, 32'd1);
    repeat (60) tick();
    vol = 16'h2020;
    repeat (60) tick();
    vol = 16'h3030;
    exp_q.push_back(32'h020B3030);
    wait_done(1'b0, 1000, "coalesce_first_done");
    tick();
    check("after_done_idle", {30'd0, busy, bus_req}, 32'd0);
    tick();
    check("after_done_req", {31'd0, bus_req}, 32'd1);
    wait_done(1'b0, 1000, "coalesce_second_done");
    repeat (400) tick();
    check("coalesce_frame_count", n_frames - frames0, 2);
    check("coalesce_quiet", {31'd0, busy}, 32'd0);

    // Reset in the middle of a frame
    vol = 16'h4444;
    hit = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (m_bits >= 15) begin hit = 1'b1; break; end
    end
    check("reset_mid_frame_reached", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("reset_mid_outputs", {29'd0, xcs, sclk, bus_req}, 32'b100);
    repeat (3) tick();
    exp_q.push_back(32'h020B4444);
    rst_n = 1'b1;
    wait_done(1'b0, 1000, "rewrite_after_reset_done");
    repeat (5) tick();
    check("exp_q_drained", exp_q.size(), 0);

    // CLK_DIV=1 instance
    exp1_q.push_back(32'h020BF0F0);
    rst1_n = 1'b1;
    wait_done(1'b1, 300, "div1_done");
    repeat (5) tick();
    check("exp1_q_drained", exp1_q.size(), 0);
    check("div1_idle", {30'd0, busy1, bus_req1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vol_sci_writer.md
# vol_sci_writer

Consumer end of the 16-bit volume word produced by the volume-setting logic. Watches VOL, and whenever it differs from the value last written to the VS1003 decoder, performs one SCI write of SCI_VOL (address 0x0B) over the shared serial control bus. The block owns the bus only while it holds a grant from the player's SPI arbiter. A write is also issued once after reset so the decoder always matches VOL.

## Interface
Parameters:
- CLK_DIV, 4, CLK cycles per SCLK half-period; legal range 1..255
- VOL_ADDR, 8'h0B, SCI register address written

Ports:
- CLK  input  1  system clock; all logic on rising edge
- RST_N  input  1  synchronous, active-low reset
- VOL  input  16  requested volume {left_atten, right_atten}; may change on any cycle
- DREQ  input  1  decoder ready; a transfer starts only while high
- BUS_GNT  input  1  arbiter grant for XCS/SCLK/SI
- BUS_REQ  output  1  bus request to arbiter
- XCS  output  1  SCI chip select, active low
- SCLK  output  1  serial clock, idle low
- SI  output  1  serial data to decoder, MSB first
- BUSY  output  1  high from leaving IDLE until return to IDLE
- DONE  output  1  one-cycle pulse when a write completes

## Operation
- Reset values: BUS_REQ=0, XCS=1, SCLK=0, SI=0, BUSY=0, DONE=0; state IDLE; sent_vol=16'h0000; pending=1 (forces the post-reset write).
- pending sets on any cycle where VOL != sent_vol. It clears only when a write completes and the latched word equals the VOL sampled that cycle.
- States:
  - IDLE: if pending -> REQ.
  - REQ: BUS_REQ=1; BUS_GNT high -> WAIT_DREQ.
  - WAIT_DREQ: BUS_REQ held; DREQ high -> SETUP.
  - SETUP: latch shift word {8'h02, VOL_ADDR, VOL}; XCS=0, SI=bit31, SCLK=0 for CLK_DIV cycles -> SHIFT.
  - SHIFT: 32 bits, each as SCLK low CLK_DIV cycles then high CLK_DIV cycles. SI changes only on the cycle SCLK goes low, so the decoder samples on the rising edge. After bit 0's high phase -> HOLD.
  - HOLD: SCLK=0, XCS=0 for CLK_DIV cycles -> RELEASE.
  - RELEASE: XCS=1, BUS_REQ=0, sent_vol<=latched data, DONE=1 -> IDLE.
- Coalescing: VOL changes during a transfer are not sent mid-frame. Comparison against the new sent_vol re-raises pending, so only the latest value is written next.
- DREQ is checked only in WAIT_DREQ; a DREQ drop mid-frame is ignored (SCI writes are short).
- BUS_GNT is checked only in REQ; the arbiter must not revoke the grant while BUS_REQ=1.
- Reset mid-transfer: on the edge that samples RST_N low, all outputs take reset values (XCS=1, SCLK=0). The partial frame is abandoned and pending=1 forces a full rewrite.
- No arithmetic on VOL; it is passed bit-exact, including 16'hf0f0 and 16'h0000.

## Timing
- VOL change sampled at edge N -> pending visible N+1 -> REQ at N+1 with BUS_REQ=1 if IDLE.
- Grant and DREQ already high: REQ -> WAIT_DREQ -> SETUP on consecutive edges.
- XCS low duration = CLK_DIV*(1+64+1) cycles; 264 cycles at CLK_DIV=4.
- DONE on the same cycle XCS returns high; the earliest next BUS_REQ is 2 cycles later (IDLE, then REQ).
- Back-to-back: a change arriving in SHIFT produces a second frame starting ≥2 cycles after DONE.

## Structure
- Shared package vs_sci_pkg: SCI_OP_WRITE=8'h02, SCI_OP_READ=8'h03, SCI register addresses (SCI_VOL=8'h0B, SCI_MODE=8'h00), state enum.
- One sub-module, sci_shift_tx: a generic 32-bit MSB-first shifter with CLK_DIV divider, start/done handshake, and SCLK/SI outputs. It is reused later for SCI_MODE writes. Top level holds the FSM, pending/sent_vol, and bus request.

## Test plan
- Reset release, VOL=16'h0000, GNT=1, DREQ=1 -> one frame 0x020B0000 on SI, XCS low 264 cycles, DONE pulse, then idle.
- VOL 0x0000->0x1010 with GNT=0 for 50 cycles -> BUS_REQ high, XCS stays 1 until GNT. Frame 0x020B1010 follows.
- DREQ=0 for 100 cycles after grant -> stays in WAIT_DREQ, SCLK=0, XCS=1. Frame begins 1 cycle after DREQ rises.
- VOL steps 0x1010->0x2020->0x3030 during one frame -> current frame completes unchanged. Exactly one further frame carrying 0x3030 follows, then no more.
- RST_N low at bit 17 of a frame -> next cycle XCS=1, SCLK=0, BUS_REQ=0. After release, full frame with current VOL.
- CLK_DIV=1, VOL=16'hf0f0 -> SCLK period 2 cycles. SI captured on each SCLK rise equals 0x020Bf0f0.
